// File: rtl/xe1ap_port_ctrl.sv
// Console joypad port sequencer for the XE-1AP analog-pad emulator: syncs REQ, freezes a coherent
// input snapshot per transaction, forwards REQ, counts nibble strobes and aborts hung trains.
module xe1ap_port_ctrl #(
  parameter int CLKPERUSEC = 50,
  parameter int TIMEOUT_US = 500,
  parameter int HOLDOFF_US = 20
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        req_in,
  input  logic [31:0] joy_in,
  input  logic [15:0] lana_in,
  input  logic [15:0] rana_in,
  input  logic        trg1_in,
  input  logic        trg2_in,
  output logic        req_out,
  output logic        xe_reset,
  output logic [31:0] joy_snap,
  output logic [15:0] lana_snap,
  output logic [15:0] rana_snap,
  output logic        busy,
  output logic        done,
  output logic        timeout_err,
  output logic [15:0] frame_cnt,
  output logic [7:0]  err_cnt
);

  localparam int PS_W   = (CLKPERUSEC > 1) ? $clog2(CLKPERUSEC) : 1;
  localparam int US_MAX = (TIMEOUT_US > HOLDOFF_US) ? TIMEOUT_US : HOLDOFF_US;
  localparam int US_W   = $clog2(US_MAX + 1);

  localparam logic [PS_W-1:0] PS_LAST    = PS_W'(CLKPERUSEC - 1);
  localparam logic [US_W-1:0] US_TIMEOUT = US_W'(TIMEOUT_US);
  localparam logic [US_W-1:0] US_HOLDOFF = US_W'(HOLDOFF_US);
  localparam logic [US_W-1:0] US_SAT     = US_W'(US_MAX);
  localparam logic [3:0]      NIB_LAST   = 4'd12;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_RUN,
    S_ABORT,
    S_GAP
  } state_t;

  state_t          state;
  logic            req_s1, req_s2;
  logic            trg1_q, trg2_q, trg2_prev;
  logic [PS_W-1:0] presc;
  logic [US_W-1:0] usec;
  logic [3:0]      nib;
  logic            abort_hold;

  logic            req_rise;
  logic            trg2_fall;
  logic            usec_tick;
  logic [US_W-1:0] usec_inc;
  logic [3:0]      nib_inc;
  logic            frame_complete;
  logic            run_expired;
  logic            gap_expired;

  assign req_rise       = req_s1 & ~req_s2;
  assign trg2_fall      = trg2_prev & ~trg2_q;
  assign usec_tick      = (presc == PS_LAST);
  assign usec_inc       = (usec == US_SAT) ? usec : usec + US_W'(1);
  assign nib_inc        = (nib == 4'hF) ? nib : nib + 4'd1;
  assign frame_complete = (nib == NIB_LAST) & ~trg1_q & trg2_q;
  assign run_expired    = (usec == US_TIMEOUT);
  assign gap_expired    = (usec == US_HOLDOFF);

  // Input conditioning and the free-running microsecond prescaler.
  // REQ idles high, so its synchronizer resets to 1 to avoid a phantom rise after reset.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      req_s1    <= 1'b1;
      req_s2    <= 1'b1;
      trg1_q    <= 1'b0;
      trg2_q    <= 1'b0;
      trg2_prev <= 1'b0;
      presc     <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      req_s1    <= req_in;
      req_s2    <= req_s1;
      trg1_q    <= trg1_in;
      trg2_q    <= trg2_in;
      trg2_prev <= trg2_q;
      presc     <= usec_tick ? '0 : presc + PS_W'(1);
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      req_out     <= 1'b1;
      xe_reset    <= 1'b1;
      joy_snap    <= '0;
      lana_snap   <= '0;
      rana_snap   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      frame_cnt   <= '0;
      err_cnt     <= '0;
      usec        <= '0;
      nib         <= '0;
      abort_hold  <= 1'b0;
    end else begin
      done        <= 1'b0;
      timeout_err <= 1'b0;
      xe_reset    <= 1'b0;
      if (usec_tick) usec <= usec_inc;

      case (state)
        S_IDLE: begin
          if (req_rise) begin
            joy_snap  <= joy_in;
            lana_snap <= lana_in;
            rana_snap <= rana_in;
            req_out   <= 1'b0;
            busy      <= 1'b1;
            state     <= S_LATCH;
          end else begin
            req_out <= req_s2;
          end
        end

        // Snapshot has been stable for a full cycle before the emulator sees REQ rise.
        S_LATCH: begin
          req_out <= 1'b1;
          nib     <= '0;
          usec    <= '0;
          state   <= S_RUN;
        end

        S_RUN: begin
          req_out <= 1'b1;
          if (trg2_fall) nib <= nib_inc;
          if (frame_complete) begin
            done      <= 1'b1;
            frame_cnt <= frame_cnt + 16'd1;
            usec      <= '0;
            state     <= S_GAP;
          end else if (run_expired) begin
            timeout_err <= 1'b1;
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            xe_reset    <= 1'b1;
            abort_hold  <= 1'b0;
            state       <= S_ABORT;
          end
        end

        // Emulator reset spans the entry cycle plus one more.
        S_ABORT: begin
          req_out <= 1'b1;
          if (abort_hold) begin
            usec  <= '0;
            state <= S_GAP;
          end else begin
            xe_reset   <= 1'b1;
            abort_hold <= 1'b1;
          end
        end

        S_GAP: begin
          req_out <= 1'b1;
          if (gap_expired) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xe1ap_port_ctrl.sv
// Self-checking bench for xe1ap_port_ctrl: directed transactions with a randomized emulator train,
// judged against a transaction-level model of outcome, counters, snapshots and timing windows.
module tb_xe1ap_port_ctrl;

  localparam int C = 2;   // clocks per usec
  localparam int T = 50;  // timeout usec
  localparam int H = 4;   // holdoff usec

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic        req_in  = 1'b1;
  logic [31:0] joy_in  = '0;
  logic [15:0] lana_in = '0;
  logic [15:0] rana_in = '0;
  logic        trg1_in = 1'b0;
  logic        trg2_in = 1'b1;

  logic        req_out, xe_reset, busy, done, timeout_err;
  logic [31:0] joy_snap;
  logic [15:0] lana_snap, rana_snap, frame_cnt;
  logic [7:0]  err_cnt;

  xe1ap_port_ctrl #(.CLKPERUSEC(C), .TIMEOUT_US(T), .HOLDOFF_US(H)) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .req_in      (req_in),
    .joy_in      (joy_in),
    .lana_in     (lana_in),
    .rana_in     (rana_in),
    .trg1_in     (trg1_in),
    .trg2_in     (trg2_in),
    .req_out     (req_out),
    .xe_reset    (xe_reset),
    .joy_snap    (joy_snap),
    .lana_snap   (lana_snap),
    .rana_snap   (rana_snap),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err),
    .frame_cnt   (frame_cnt),
    .err_cnt     (err_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_done, n_to, n_xe, done_cyc, to_cyc;
  int frame_exp = 0;
  int err_exp = 0;
  logic [31:0] prev_joy;
  logic [15:0] prev_lana, prev_rana;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // One clock; outputs sampled 1 time unit after the edge, pulse events tallied.
  task automatic step();
    prev_joy  = joy_snap;
    prev_lana = lana_snap;
    prev_rana = rana_snap;
    @(posedge clk_sys);
    #1;
    cyc++;
    if (done === 1'b1) begin n_done++; done_cyc = cyc; end
    if (timeout_err === 1'b1) begin n_to++; to_cyc = cyc; end
    if (xe_reset === 1'b1) n_xe++;
  endtask

  task automatic scramble_live();
    joy_in  = $urandom;
    lana_in = 16'($urandom);
    rana_in = 16'($urandom);
  endtask

  // end_mode: 0 = REQ high after train, 1 = low/high glitch during holdoff, 2 = REQ held low through exit
  task automatic do_txn(input logic [31:0] joy_val, input int nfalls, input bit fin_trg1, input int end_mode);
    bit          expect_done;
    bit          ended;
    int          rise_cyc, fall_cyc, run_low, busy_high;
    logic [15:0] lana_val, rana_val;

    expect_done = (nfalls == 12) && !fin_trg1;
    n_done = 0; n_to = 0; n_xe = 0;
    trg1_in = 1'b0;
    trg2_in = 1'b1;

    req_in = 1'b0;
    repeat (4 + $urandom_range(0, 3)) begin scramble_live(); step(); end
    check("req_pass_low", req_out, 1'b0);
    check("idle_not_busy", busy, 1'b0);

    joy_in   = joy_val;
    lana_val = 16'($urandom);
    rana_val = 16'($urandom);
    lana_in  = lana_val;
    rana_in  = rana_val;
    req_in   = 1'b1;
    step();
    step();
    check("req_low_at_capture", req_out, 1'b0);
    check("busy_at_capture", busy, 1'b1);
    step();
    rise_cyc = cyc;
    check("req_out_rise", req_out, 1'b1);
    check("joy_snap_before_rise", prev_joy, joy_val);
    check("lana_snap_before_rise", prev_lana, lana_val);
    check("rana_snap_before_rise", prev_rana, rana_val);

    // Emulator train; console REQ and live inputs churn throughout.
    run_low = 0;
    trg1_in = 1'b1;
    for (int i = 0; i < nfalls; i++) begin
      trg2_in = 1'b0;
      repeat ($urandom_range(1, 2)) begin
        scramble_live(); req_in = 1'($urandom); step();
        if (req_out !== 1'b1) run_low++;
      end
      trg2_in = 1'b1;
      repeat ($urandom_range(1, 2)) begin
        scramble_live(); req_in = 1'($urandom); step();
        if (req_out !== 1'b1) run_low++;
      end
    end
    check("req_out_high_in_run", run_low, 0);
    trg1_in = fin_trg1;
    req_in  = 1'b1;

    ended = 1'b0;
    for (int k = 0; k < T * C + 20 && !ended; k++) begin
      scramble_live();
      step();
      ended = (n_done + n_to) != 0;
    end
    check("txn_ended_in_bound", ended, 1'b1);

    if (end_mode == 1) begin
      req_in = 1'b0; step(); req_in = 1'b1;
    end else if (end_mode == 2) begin
      req_in = 1'b0;
    end

    for (int k = 0; k < H * C + 20 && busy === 1'b1; k++) begin
      scramble_live();
      step();
    end
    fall_cyc = cyc;
    check("busy_falls", busy, 1'b0);

    check("done_pulses", n_done, expect_done ? 1 : 0);
    check("timeout_pulses", n_to, expect_done ? 0 : 1);
    check("xe_reset_cycles", n_xe, expect_done ? 0 : 2);
    if (expect_done) begin
      check_range("holdoff_after_done", fall_cyc - done_cyc, (H - 1) * C, H * C + 2);
      frame_exp = (frame_exp + 1) % 65536;
    end else begin
      check_range("timeout_latency", to_cyc - rise_cyc, (T - 1) * C, T * C + 2);
      check_range("holdoff_after_abort", fall_cyc - to_cyc, (H - 1) * C + 2, H * C + 4);
      if (err_exp < 255) err_exp++;
    end
    check("frame_cnt", frame_cnt, 64'(frame_exp));
    check("err_cnt", err_cnt, 64'(err_exp));
    check("joy_snap_held", joy_snap, joy_val);
    check("lana_snap_held", lana_snap, lana_val);
    check("rana_snap_held", rana_snap, rana_val);

    busy_high = 0;
    repeat (4) begin
      scramble_live(); step();
      if (busy !== 1'b0) busy_high++;
    end
    check("no_restart_after_gap", busy_high, 0);
    check("req_out_after_gap", req_out, (end_mode == 2) ? 1'b0 : 1'b1);
  endtask

  initial begin
    int tbl_falls[8] = '{12, 12, 12, 11, 13, 5, 0, 16};

    step();
    step();
    check("rst_req_out", req_out, 1'b1);
    check("rst_xe_reset", xe_reset, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_timeout", timeout_err, 1'b0);
    check("rst_joy_snap", joy_snap, 32'h0);
    check("rst_frame_cnt", frame_cnt, 16'h0);
    check("rst_err_cnt", err_cnt, 8'h0);
    reset = 1'b0;
    step();
    check("rel_xe_reset", xe_reset, 1'b0);
    check("rel_req_out", req_out, 1'b1);

    do_txn(32'h0000_0000, 12, 1'b0, 0);
    do_txn(32'h0000_00FF, 12, 1'b0, 1);
    do_txn($urandom, 5, 1'b0, 0);
    do_txn($urandom, 12, 1'b0, 2);
    do_txn($urandom, 12, 1'b1, 0);

    for (int n = 0; n < 20; n++)
      do_txn($urandom, tbl_falls[$urandom_range(0, 7)], ($urandom_range(0, 3) == 0), $urandom_range(0, 2));

    for (int n = 0; n < 256; n++)
      do_txn($urandom, $urandom_range(0, 11), 1'b0, 0);
    check("err_cnt_saturated", err_cnt, 8'hFF);

    // Reset in the middle of a train.
    req_in = 1'b0;
    repeat (5) step();
    req_in = 1'b1;
    repeat (3) step();
    trg1_in = 1'b1;
    repeat (5) begin
      trg2_in = 1'b0; step();
      trg2_in = 1'b1; step();
    end
    repeat (6) step();
    check("busy_before_midrun_reset", busy, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_req_out", req_out, 1'b1);
    check("mid_rst_xe_reset", xe_reset, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_timeout", timeout_err, 1'b0);
    check("mid_rst_snaps", {joy_snap, lana_snap, rana_snap}, 64'h0);
    check("mid_rst_counters", {frame_cnt, err_cnt}, 24'h0);
    trg1_in = 1'b0;
    repeat (3) step();
    check("mid_rst_xe_hold", xe_reset, 1'b1);
    reset = 1'b0;
    frame_exp = 0;
    err_exp = 0;
    step();
    check("mid_rel_xe_reset", xe_reset, 1'b0);
    do_txn($urandom, 12, 1'b0, 0);
    check("frame_after_reset", frame_cnt, 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
